// File: rtl/fifo_enq_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// fifo_enq_arbiter_pkg
// Shared definitions for the FIFO enqueue arbiter:
//   arb_state_e  - arbiter mode (IDLE: round-robin, LOCKED: one owner bursting)
//   GRANT_CNT_W  - width of the accepted-beat statistics counter
//   BURST_W      - width of the per-lock beat counter
//   wrap_inc()   - modulo-n increment used for round-robin pointer updates
// ----------------------------------------------------------------------------
package fifo_enq_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int GRANT_CNT_W = 16;
  localparam int BURST_W     = 8;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    int nxt;
    nxt = idx + 32'sd1;
    if (nxt >= n) begin
      nxt = 32'sd0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_enq_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Purely combinational rotating-priority search.
//   valid [count-1:0] : candidate request vector
//   base  [IDX_W-1:0] : index with highest priority this cycle
//   index [IDX_W-1:0] : first set bit at base, base+1, ... (mod count)
//   found             : at least one bit of valid is set
// index is zero when nothing is found.
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int count = 4,
  parameter int IDX_W = $clog2(count)
) (
  input  logic [count-1:0] valid,
  input  logic [IDX_W-1:0] base,
  output logic [IDX_W-1:0] index,
  output logic             found
);

  logic [IDX_W-1:0] cand_s;

  // Walk the ring starting at base; the first valid candidate wins.
  always_comb begin
    index  = '0;
    found  = 1'b0;
    cand_s = '0;
    for (int k = 0; k < count; k++) begin
      cand_s = IDX_W'((int'(base) + k) % count);
      if (!found && valid[cand_s]) begin
        index = cand_s;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_enq_arbiter
// Shares one FIFO enqueue port between `count` requesters. In IDLE the grant
// rotates round-robin from ptr; a requester holding req_lock keeps the grant
// for up to maxBurst beats (LOCKED), after which the pointer moves past it.
// Ports:
//   CLK, nRST          : clock, asynchronous active-low reset
//   req_valid[i]       : requester i has data pending
//   req_lock[i]        : requester i wants to keep the grant after this beat
//   req_enq_ena[i]     : requester i enqueues (honoured only with RDY[i])
//   req_enq_v          : requester data, requester i at [i*width +: width]
//   req_enq_rdy        : one-hot-or-zero grant, qualified by FIFO ready
//   out_enq_ena/_v     : enqueue strobe and data to the FIFO
//   out_enq_rdy        : FIFO not full
//   stat_grant_count   : accepted beats since reset (wraps)
// ----------------------------------------------------------------------------
module fifo_enq_arbiter
  import fifo_enq_arbiter_pkg::*;
#(
  parameter int count    = 4,
  parameter int width    = 128,
  parameter int maxBurst = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [count-1:0]       req_valid,
  input  logic [count-1:0]       req_lock,
  input  logic [count-1:0]       req_enq_ena,
  input  logic [count*width-1:0] req_enq_v,
  output logic [count-1:0]       req_enq_rdy,
  output logic                   out_enq_ena,
  output logic [width-1:0]       out_enq_v,
  input  logic                   out_enq_rdy,
  output logic [GRANT_CNT_W-1:0] stat_grant_count
);

  localparam int                 IDX_W       = $clog2(count);
  localparam logic [BURST_W-1:0] MAX_BURST_B = BURST_W'(maxBurst);
  // A one-beat burst limit makes locking meaningless; stay in IDLE.
  localparam bit                 LOCK_EN     = (maxBurst > 32'sd1);

  arb_state_e             fsm_r,   fsm_nx_s;
  logic [IDX_W-1:0]       ptr_r,   ptr_nx_s;
  logic [IDX_W-1:0]       owner_r, owner_nx_s;
  logic [BURST_W-1:0]     burst_r, burst_nx_s;
  logic [GRANT_CNT_W-1:0] cnt_r,   cnt_nx_s;

  logic [IDX_W-1:0]       pick_idx_s;
  logic                   pick_found_s;
  logic [IDX_W-1:0]       grant_idx_s;
  logic                   grant_vld_s;
  logic                   acc_s;

  rr_pick #(
    .count (count),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .valid (req_valid),
    .base  (ptr_r),
    .index (pick_idx_s),
    .found (pick_found_s)
  );

  // State register: all arbiter state and the statistics counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fsm_r   <= IDLE;
      ptr_r   <= '0;
      owner_r <= '0;
      burst_r <= '0;
      cnt_r   <= '0;
    end else begin
      fsm_r   <= fsm_nx_s;
      ptr_r   <= ptr_nx_s;
      owner_r <= owner_nx_s;
      burst_r <= burst_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state logic: lock entry, burst counting, release and pointer moves.
  always_comb begin
    fsm_nx_s   = fsm_r;
    ptr_nx_s   = ptr_r;
    owner_nx_s = owner_r;
    burst_nx_s = burst_r;
    if (acc_s) begin
      cnt_nx_s = cnt_r + GRANT_CNT_W'(1'b1);
    end else begin
      cnt_nx_s = cnt_r;
    end
    case (fsm_r)
      IDLE: begin
        if (acc_s) begin
          if (req_lock[grant_idx_s] && LOCK_EN) begin
            fsm_nx_s   = LOCKED;
            owner_nx_s = grant_idx_s;
            burst_nx_s = BURST_W'(1'b1);
          end else begin
            ptr_nx_s = IDX_W'(wrap_inc(int'(grant_idx_s), count));
          end
        end else begin
          fsm_nx_s = IDLE;
        end
      end
      LOCKED: begin
        if (acc_s) begin
          burst_nx_s = burst_r + BURST_W'(1'b1);
          if (!req_lock[owner_r] || (burst_r + BURST_W'(1'b1) == MAX_BURST_B)) begin
            fsm_nx_s = IDLE;
            ptr_nx_s = IDX_W'(wrap_inc(int'(owner_r), count));
          end else begin
            fsm_nx_s = LOCKED;
          end
        end else if (out_enq_rdy && !req_valid[owner_r]) begin
          // Owner dropped valid: give the port back rather than stall others.
          fsm_nx_s = IDLE;
          ptr_nx_s = IDX_W'(wrap_inc(int'(owner_r), count));
        end else begin
          fsm_nx_s = LOCKED;
        end
      end
      default: begin
        fsm_nx_s   = IDLE;
        ptr_nx_s   = '0;
        owner_nx_s = '0;
        burst_nx_s = '0;
      end
    endcase
  end

  // Output logic: grant selection, ready vector, enqueue strobe and data mux.
  always_comb begin
    grant_idx_s = '0;
    grant_vld_s = 1'b0;
    req_enq_rdy = '0;
    out_enq_v   = '0;
    case (fsm_r)
      IDLE: begin
        grant_idx_s = pick_idx_s;
        grant_vld_s = pick_found_s;
      end
      LOCKED: begin
        // No bypass: others wait while the owner holds the lock.
        grant_idx_s = owner_r;
        grant_vld_s = req_valid[owner_r];
      end
      default: begin
        grant_idx_s = '0;
        grant_vld_s = 1'b0;
      end
    endcase
    // nRST gates outputs so reset silences the port even with live requests.
    if (nRST && grant_vld_s) begin
      out_enq_v = req_enq_v[int'(grant_idx_s)*width +: width];
      if (out_enq_rdy) begin
        req_enq_rdy[grant_idx_s] = 1'b1;
      end else begin
        req_enq_rdy = '0;
      end
    end else begin
      out_enq_v = '0;
    end
    out_enq_ena = |(req_enq_ena & req_enq_rdy);
    acc_s       = out_enq_ena;
  end

  assign stat_grant_count = cnt_r;

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_enq_arbiter
// Directed stimulus for a 4-requester, maxBurst=3 arbiter. A queue-free
// reference model (ring search, lock/burst bookkeeping, beat counter) is
// checked against the DUT on every falling edge; the directed cycles also
// carry hand-computed grant vectors and counter values.
// ----------------------------------------------------------------------------
module tb_fifo_enq_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 3;

  logic           CLK = 1'b0;
  logic           nRST;
  logic [N-1:0]   valid, lock, ena_mask, ena_force, req_ena;
  logic [N*W-1:0] data_bus;
  logic           fifo_rdy;
  logic [N-1:0]   rdy;
  logic           ena_out;
  logic [W-1:0]   dout;
  logic [15:0]    gcnt;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_ptr, m_owner, m_burst, m_cnt;
  bit m_locked;

  // Requesters raise ENA only when granted, plus optional illegal ENA.
  assign req_ena = (ena_mask & rdy) | ena_force;

  fifo_enq_arbiter #(.count(N), .width(W), .maxBurst(MB)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .req_valid        (valid),
    .req_lock         (lock),
    .req_enq_ena      (req_ena),
    .req_enq_v        (data_bus),
    .req_enq_rdy      (rdy),
    .out_enq_ena      (ena_out),
    .out_enq_v        (dout),
    .out_enq_rdy      (fifo_rdy),
    .stat_grant_count (gcnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the reference model, then model update.
  always @(negedge CLK) begin
    bit          g_vld;
    int          g_idx;
    int          c;
    logic [N-1:0] e_rdy;
    logic        e_ena;
    logic [W-1:0] e_data;
    if (!nRST) begin
      m_ptr = 0; m_owner = 0; m_burst = 0; m_cnt = 0; m_locked = 0;
    end
    g_vld = 0;
    g_idx = 0;
    if (!m_locked) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!g_vld && valid[c]) begin
          g_vld = 1;
          g_idx = c;
        end
      end
    end else begin
      g_vld = valid[m_owner];
      g_idx = m_owner;
    end
    e_rdy  = (nRST && fifo_rdy && g_vld) ? N'(32'd1 << g_idx) : '0;
    e_ena  = |((ena_mask | ena_force) & e_rdy);
    e_data = (nRST && g_vld) ? data_bus[g_idx*W +: W] : '0;
    chk("mdl_rdy",  32'(rdy),     32'(e_rdy));
    chk("mdl_ena",  32'(ena_out), 32'(e_ena));
    chk("mdl_data", dout,         e_data);
    chk("mdl_cnt",  32'(gcnt),    32'(m_cnt));
    if (nRST) begin
      if (e_ena) begin
        m_cnt = (m_cnt + 1) % 65536;
        if (!m_locked) begin
          if (lock[g_idx] && MB > 1) begin
            m_locked = 1; m_owner = g_idx; m_burst = 1;
          end else begin
            m_ptr = (g_idx + 1) % N;
          end
        end else begin
          m_burst = m_burst + 1;
          if (!lock[m_owner] || m_burst == MB) begin
            m_locked = 0; m_ptr = (m_owner + 1) % N;
          end
        end
      end else if (m_locked && fifo_rdy && !valid[m_owner]) begin
        m_locked = 0; m_ptr = (m_owner + 1) % N;
      end
    end
  end

  // One cycle of stimulus, optionally checking a hand-computed grant vector.
  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] l, input logic fr,
                     input logic [N-1:0] em, input logic [N-1:0] ef,
                     input logic [N-1:0] exp_rdy, input bit do_chk);
    @(posedge CLK); #1;
    valid = v; lock = l; fifo_rdy = fr; ena_mask = em; ena_force = ef;
    for (int i = 0; i < N; i++) data_bus[i*W +: W] = $urandom;
    @(negedge CLK);
    if (do_chk) chk("dir_rdy", 32'(rdy), 32'(exp_rdy));
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    @(posedge CLK); #1;
    nRST = 1'b0; valid = v; lock = '0; fifo_rdy = 1'b1; ena_mask = '1; ena_force = '0;
    #1;
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_ena", 32'(ena_out), 32'd0);
    @(negedge CLK);
    @(posedge CLK); #1;
    nRST = 1'b1; valid = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; valid = '0; lock = '0; fifo_rdy = 1'b1;
    ena_mask = '1; ena_force = '0; data_bus = '0;
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Plain round robin: 0,1,2,3,0 then five beats counted.
    cyc(4'hF, 4'h0, 1'b1, 4'hF, 4'h0, 4'b0001, 1);
    cyc(4'hF, 4'h0, 1'b1, 4'hF, 4'h0, 4'b0010, 1);
    cyc(4'hF, 4'h0, 1'b1, 4'hF, 4'h0, 4'b0100, 1);
    cyc(4'hF, 4'h0, 1'b1, 4'hF, 4'h0, 4'b1000, 1);
    cyc(4'hF, 4'h0, 1'b1, 4'hF, 4'h0, 4'b0001, 1);
    cyc(4'h0, 4'h0, 1'b1, 4'hF, 4'h0, 4'b0000, 1);
    chk("cnt_5", 32'(gcnt), 32'd5);

    // Sparse valid with ptr at 3: grants 1, 2, 1.
    do_reset(4'hF);
    cyc(4'b0100, 4'h0, 1'b1, 4'hF, 4'h0, 4'b0100, 1);
    cyc(4'b0110, 4'h0, 1'b1, 4'hF, 4'h0, 4'b0010, 1);
    cyc(4'b0110, 4'h0, 1'b1, 4'hF, 4'h0, 4'b0100, 1);
    cyc(4'b0110, 4'h0, 1'b1, 4'hF, 4'h0, 4'b0010, 1);

    // Lock by requester 2, burst limit 3 forces release to 3.
    cyc(4'hF, 4'b0100, 1'b1, 4'hF, 4'h0, 4'b0100, 1);
    cyc(4'hF, 4'b0100, 1'b1, 4'hF, 4'h0, 4'b0100, 1);
    cyc(4'hF, 4'b0100, 1'b1, 4'hF, 4'h0, 4'b0100, 1);
    cyc(4'hF, 4'b0100, 1'b1, 4'hF, 4'h0, 4'b1000, 1);

    // FIFO full for 5 cycles mid-lock; owner 0 resumes with burst held.
    cyc(4'hF, 4'b0001, 1'b1, 4'hF, 4'h0, 4'b0001, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(4'hF, 4'b0001, 1'b0, 4'hF, 4'h0, 4'b0000, 1);
      chk("full_ena", 32'(ena_out), 32'd0);
    end
    cyc(4'hF, 4'b0001, 1'b1, 4'hF, 4'h0, 4'b0001, 1);
    cyc(4'hF, 4'b0001, 1'b1, 4'hF, 4'h0, 4'b0001, 1);
    cyc(4'hF, 4'b0000, 1'b1, 4'hF, 4'h0, 4'b0010, 1);

    // ENA from a non-granted requester is ignored; grant stays on 2.
    cyc(4'hF, 4'h0, 1'b1, 4'h0, 4'b1000, 4'b0100, 1);
    chk("bad_ena", 32'(ena_out), 32'd0);
    cyc(4'hF, 4'h0, 1'b1, 4'h0, 4'b1000, 4'b0100, 1);
    chk("bad_ena", 32'(ena_out), 32'd0);
    cyc(4'hF, 4'h0, 1'b1, 4'hF, 4'h0, 4'b0100, 1);

    // Owner 3 abandons its lock; pointer moves to 0.
    cyc(4'hF, 4'b1000, 1'b1, 4'hF, 4'h0, 4'b1000, 1);
    cyc(4'b0111, 4'b1000, 1'b1, 4'hF, 4'h0, 4'b0000, 1);
    cyc(4'hF, 4'b0000, 1'b1, 4'hF, 4'h0, 4'b0001, 1);

    // Reset during LOCKED owner=1 burst=2; first grant afterwards is 0.
    cyc(4'b0010, 4'b0010, 1'b1, 4'hF, 4'h0, 4'b0010, 1);
    cyc(4'b0010, 4'b0010, 1'b1, 4'hF, 4'h0, 4'b0010, 1);
    do_reset(4'hF);
    cyc(4'hF, 4'h0, 1'b1, 4'hF, 4'h0, 4'b0001, 1);

    // Counter wrap: 65535 beats read 16'hFFFF, one more reads 0.
    do_reset(4'hF);
    for (int i = 0; i < 65535; i++) cyc(4'hF, 4'h0, 1'b1, 4'hF, 4'h0, 4'h0, 0);
    cyc(4'h0, 4'h0, 1'b1, 4'hF, 4'h0, 4'b0000, 1);
    chk("cnt_ffff", 32'(gcnt), 32'h0000_FFFF);
    cyc(4'hF, 4'h0, 1'b1, 4'hF, 4'h0, 4'b1000, 1);
    cyc(4'h0, 4'h0, 1'b1, 4'hF, 4'h0, 4'b0000, 1);
    chk("cnt_wrap", 32'(gcnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
